// File: rtl/line_engine_q.sv
// rtl/line_engine_q.sv - queued Bresenham line rasteriser emitting masked 2-beat DDR bursts
// Pixels sharing an 8-pixel block are coalesced; off-screen pixels are clipped away.
module line_engine_q #(
  parameter int CW    = 10,
  parameter int DEPTH = 4,
  parameter int H_RES = 800,
  parameter int V_RES = 600
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [CW-1:0] cmd_x0,
  input  logic [CW-1:0] cmd_y0,
  input  logic [CW-1:0] cmd_x1,
  input  logic [CW-1:0] cmd_y1,
  input  logic [23:0]   cmd_color,
  input  logic [31:0]   frame_base,
  input  logic          af_full,
  input  logic          wdf_full,
  output logic [30:0]   af_addr_din,
  output logic          af_wr_en,
  output logic [127:0]  wdf_din,
  output logic [15:0]   wdf_mask_din,
  output logic          wdf_wr_en,
  output logic          busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 4*CW + 24;
  localparam logic [31:0] H_LIM = 32'(H_RES);
  localparam logic [31:0] V_LIM = 32'(V_RES);

  typedef enum logic [2:0] {IDLE, SETUP, STEP, WR1, WR2} state_t;

  logic [EW-1:0] q_mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          q_empty, q_full, push;

  state_t               state;
  logic [CW-1:0]        x0_r, y0_r, x1_r, y1_r;
  logic [23:0]          color_r;
  logic [28:0]          base_r;
  logic [CW-1:0]        x, y, xend;
  logic [CW:0]          dx, ady;
  logic signed [CW+1:0] err;
  logic                 steep, ystep_neg, done;
  logic [7:0]           blk_mask, burst_mask;
  logic                 unused_base;

  assign q_empty     = (wr_ptr == rd_ptr);
  assign q_full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign push        = cmd_valid && !q_full;
  assign cmd_ready   = !q_full;
  assign busy        = !q_empty || (state != IDLE);
  assign unused_base = ^frame_base[2:0];

  always_ff @(posedge clk)
    if (push) q_mem[wr_ptr[AW-1:0]] <= {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color};

  // Line setup: fold the octant so the major axis always steps +1 in x
  logic [CW:0]   adx_c, ady_c, dmaj_c, dmin_c;
  logic [CW-1:0] a0_c, b0_c, a1_c, b1_c;
  logic          steep_c, swap_c;

  assign adx_c   = (x1_r >= x0_r) ? {1'b0, x1_r} - {1'b0, x0_r} : {1'b0, x0_r} - {1'b0, x1_r};
  assign ady_c   = (y1_r >= y0_r) ? {1'b0, y1_r} - {1'b0, y0_r} : {1'b0, y0_r} - {1'b0, y1_r};
  assign steep_c = ady_c > adx_c;
  assign a0_c    = steep_c ? y0_r : x0_r;
  assign b0_c    = steep_c ? x0_r : y0_r;
  assign a1_c    = steep_c ? y1_r : x1_r;
  assign b1_c    = steep_c ? x1_r : y1_r;
  assign swap_c  = a0_c > a1_c;
  assign dmaj_c  = steep_c ? ady_c : adx_c;
  assign dmin_c  = steep_c ? adx_c : ady_c;

  logic [CW-1:0]        px, py, nx, ny, npx, npy;
  logic signed [CW+1:0] err_dec;
  logic                 last, new_blk, hit;
  logic [7:0]           cur_mask;
  logic [30:0]          addr_c;

  assign px       = steep ? y : x;
  assign py       = steep ? x : y;
  assign err_dec  = err - $signed({1'b0, ady});
  assign nx       = x + 1'b1;
  assign ny       = err_dec[CW+1] ? (ystep_neg ? y - 1'b1 : y + 1'b1) : y;
  assign npx      = steep ? ny : nx;
  assign npy      = steep ? nx : ny;
  assign last     = (x == xend);
  assign new_blk  = last || (npy != py) || (npx[CW-1:3] != px[CW-1:3]);
  assign hit      = (32'(px) < H_LIM) && (32'(py) < V_LIM);
  assign cur_mask = blk_mask & ~(hit ? (8'd1 << px[2:0]) : 8'd0);
  assign addr_c   = 31'(base_r) + 31'({py, px[CW-1:3], 2'b00});

  logic [15:0] beat1_mask, beat2_mask;
  assign beat1_mask = {{4{burst_mask[0]}}, {4{burst_mask[1]}}, {4{burst_mask[2]}}, {4{burst_mask[3]}}};
  assign beat2_mask = {{4{burst_mask[4]}}, {4{burst_mask[5]}}, {4{burst_mask[6]}}, {4{burst_mask[7]}}};

  // Push strobes are gated by the full flags directly so a push never lands on a full FIFO
  assign af_wr_en     = (state == WR1) && !af_full && !wdf_full;
  assign wdf_wr_en    = af_wr_en || ((state == WR2) && !wdf_full);
  assign wdf_mask_din = af_wr_en ? beat1_mask : (wdf_wr_en ? beat2_mask : 16'hFFFF);
  assign wdf_din      = {4{8'h00, color_r}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;     wr_ptr <= '0;      rd_ptr <= '0;
      x0_r <= '0;        y0_r <= '0;        x1_r <= '0;       y1_r <= '0;
      color_r <= '0;     base_r <= '0;      x <= '0;          y <= '0;
      xend <= '0;        dx <= '0;          ady <= '0;        err <= '0;
      steep <= 1'b0;     ystep_neg <= 1'b0; done <= 1'b0;
      blk_mask <= 8'hFF; burst_mask <= 8'hFF; af_addr_din <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case (state)
        IDLE: if (!q_empty) begin
          {x0_r, y0_r, x1_r, y1_r, color_r} <= q_mem[rd_ptr[AW-1:0]];
          base_r <= frame_base[31:3];
          rd_ptr <= rd_ptr + 1'b1;
          state  <= SETUP;
        end
        SETUP: begin
          x         <= swap_c ? a1_c : a0_c;
          y         <= swap_c ? b1_c : b0_c;
          xend      <= swap_c ? a0_c : a1_c;
          ystep_neg <= swap_c ? (b0_c < b1_c) : (b1_c < b0_c);
          steep     <= steep_c;
          dx        <= dmaj_c;
          ady       <= dmin_c;
          err       <= $signed({2'b00, dmaj_c[CW:1]});
          blk_mask  <= 8'hFF;
          state     <= STEP;
        end
        STEP: begin
          x   <= nx;
          y   <= ny;
          err <= err_dec[CW+1] ? err_dec + $signed({1'b0, dx}) : err_dec;
          if (new_blk) begin
            blk_mask <= 8'hFF;
            done     <= last;
            if (cur_mask == 8'hFF) begin
              state <= last ? IDLE : STEP;
            end else begin
              burst_mask  <= cur_mask;
              af_addr_din <= addr_c;
              state       <= WR1;
            end
          end else begin
            blk_mask <= cur_mask;
          end
        end
        WR1: if (!af_full && !wdf_full) state <= WR2;
        WR2: if (!wdf_full) state <= done ? IDLE : STEP;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_engine_q.sv
// tb/tb_line_engine_q.sv - randomized self-checking bench for line_engine_q
// Expected bursts come from a textbook pixel-list model grouped into 8-pixel blocks.
module tb_line_engine_q;
  localparam int CW = 10, DEPTH = 4, H_RES = 800, V_RES = 600;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic          cmd_valid, cmd_ready;
  logic [CW-1:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [23:0]   cmd_color;
  logic [31:0]   frame_base;
  logic          af_full, wdf_full;
  logic [30:0]   af_addr_din;
  logic          af_wr_en, wdf_wr_en, busy;
  logic [127:0]  wdf_din;
  logic [15:0]   wdf_mask_din;

  line_engine_q #(.CW(CW), .DEPTH(DEPTH), .H_RES(H_RES), .V_RES(V_RES)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .frame_base(frame_base), .af_full(af_full), .wdf_full(wdf_full),
    .af_addr_din(af_addr_din), .af_wr_en(af_wr_en), .wdf_din(wdf_din),
    .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en), .busy(busy)
  );

  always #5 clk = ~clk;

  int           vectors = 0, miscompares = 0, af_seen = 0;
  logic [30:0]  exp_af[$];
  logic [143:0] exp_wd[$];
  bit           rand_full = 0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  // Reference: plain Bresenham pixel list, clipped, grouped by (y, x/8) into 2-beat bursts
  task automatic model_line(input int ax0, input int ay0, input int ax1, input int ay1, input logic [23:0] col);
    int x0, y0, x1, y1, t, dx, dy, err, ys, yy, s, n;
    bit steep, hit;
    int pxs[$], pys[$];
    logic [15:0] m1, m2;
    logic [31:0] a32;
    x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1;
    steep = iabs(y1 - y0) > iabs(x1 - x0);
    if (steep) begin t = x0; x0 = y0; y0 = t; t = x1; x1 = y1; y1 = t; end
    if (x0 > x1) begin t = x0; x0 = x1; x1 = t; t = y0; y0 = y1; y1 = t; end
    dx = x1 - x0; dy = iabs(y1 - y0); err = dx / 2; ys = (y0 < y1) ? 1 : -1; yy = y0;
    for (int xx = x0; xx <= x1; xx++) begin
      pxs.push_back(steep ? yy : xx);
      pys.push_back(steep ? xx : yy);
      err -= dy;
      if (err < 0) begin yy += ys; err += dx; end
    end
    m1 = 16'hFFFF; m2 = 16'hFFFF; hit = 0; n = pxs.size();
    for (int i = 0; i < n; i++) begin
      if (pxs[i] < H_RES && pys[i] < V_RES) begin
        s = pxs[i] % 8; hit = 1;
        for (int b = 0; b < 4; b++) begin
          if (s < 4) m1[15 - 4*(s%4) - b] = 1'b0;
          else       m2[15 - 4*(s%4) - b] = 1'b0;
        end
      end
      if (i == n-1 || pys[i+1] != pys[i] || pxs[i+1]/8 != pxs[i]/8) begin
        if (hit) begin
          a32 = (frame_base >> 3) + 32'(pys[i]*512 + (pxs[i]/8)*4);
          exp_af.push_back(a32[30:0]);
          exp_wd.push_back({m1, {4{8'h00, col}}});
          exp_wd.push_back({m2, {4{8'h00, col}}});
        end
        m1 = 16'hFFFF; m2 = 16'hFFFF; hit = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (af_wr_en) begin
        af_seen++;
        check("af_push_while_full", 160'(af_full), 160'd0);
        if (exp_af.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL af_unexpected: got push addr %0h, required no push", af_addr_din);
        end else check("af_addr", 160'(af_addr_din), 160'(exp_af.pop_front()));
      end
      if (wdf_wr_en) begin
        check("wdf_push_while_full", 160'(wdf_full), 160'd0);
        if (exp_wd.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL wdf_unexpected: got push mask %0h, required no push", wdf_mask_din);
        end else check("wdf_beat", 160'({wdf_mask_din, wdf_din}), 160'(exp_wd.pop_front()));
      end else begin
        check("idle_mask", 160'(wdf_mask_din), 160'hFFFF);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rand_full) begin
      af_full  = ($urandom_range(0, 3) == 0);
      wdf_full = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic push_cmd(input int a, input int b, input int c, input int d, input logic [23:0] col);
    int n;
    n = 0;
    while (!cmd_ready && n < 5000) begin tick(); n++; end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", 160'(cmd_ready), 160'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_x0 = a[CW-1:0]; cmd_y0 = b[CW-1:0]; cmd_x1 = c[CW-1:0]; cmd_y1 = d[CW-1:0];
    cmd_color = col;
    model_line(a, b, c, d, col);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (busy && n < 30000) begin tick(); n++; end
    tick(); tick();
    check({name, "_busy_after_drain"}, 160'(busy), 160'd0);
    check({name, "_af_left"}, 160'(exp_af.size()), 160'd0);
    check({name, "_wdf_left"}, 160'(exp_wd.size()), 160'd0);
    exp_af.delete(); exp_wd.delete();
  endtask

  function automatic int clampc(input int v);
    return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
  endfunction

  logic [15:0] diag_mask [4];
  initial begin
    int n, s, x0, y0, x1, y1, span;
    diag_mask = '{16'h0FFF, 16'hF0FF, 16'hFF0F, 16'hFFF0};
    cmd_valid = 0; cmd_x0 = 0; cmd_y0 = 0; cmd_x1 = 0; cmd_y1 = 0; cmd_color = 0;
    frame_base = 0; af_full = 0; wdf_full = 0;
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_af_wr_en", 160'(af_wr_en), 160'd0);
    check("rst_wdf_wr_en", 160'(wdf_wr_en), 160'd0);
    check("rst_af_addr", 160'(af_addr_din), 160'd0);
    check("rst_mask", 160'(wdf_mask_din), 160'hFFFF);
    check("rst_busy", 160'(busy), 160'd0);
    check("rst_cmd_ready", 160'(cmd_ready), 160'd1);
    rst_n = 1;
    tick();

    // 1: full horizontal block, latency from push
    push_cmd(0, 0, 7, 0, 24'hFF0000);
    check("t1_model_n", 160'(exp_af.size()), 160'd1);
    check("t1_model_addr", 160'(exp_af[0]), 160'd0);
    check("t1_model_beat1", 160'(exp_wd[0]), 160'({16'h0000, {4{32'h00FF0000}}}));
    check("t1_model_beat2", 160'(exp_wd[1]), 160'({16'h0000, {4{32'h00FF0000}}}));
    n = 0;
    while (!af_wr_en && n < 20) begin tick(); n++; end
    check("t1_af_seen", 160'(af_wr_en), 160'd1);
    check("t1_latency_ge3", 160'(n >= 3), 160'd1);
    drain("t1");

    // 2: partial block straddling the beat boundary
    push_cmd(3, 0, 5, 0, 24'h00FF00);
    check("t2_model_m1", 160'(exp_wd[0][143:128]), 160'hFFF0);
    check("t2_model_m2", 160'(exp_wd[1][143:128]), 160'h00FF);
    drain("t2");

    // 3: vertical line, one burst per row
    frame_base = 32'h0040_0000;
    push_cmd(2, 0, 2, 3, 24'h123456);
    check("t3_model_n", 160'(exp_af.size()), 160'd4);
    for (int k = 0; k < 4; k++) begin
      check("t3_model_addr", 160'(exp_af[k]), 160'(31'h0008_0000 + 31'(k << 9)));
      check("t3_model_m1", 160'(exp_wd[2*k][143:128]), 160'hFF0F);
      check("t3_model_m2", 160'(exp_wd[2*k+1][143:128]), 160'hFFFF);
    end
    drain("t3");

    // 4: reversed endpoints and a diagonal
    frame_base = 0;
    push_cmd(7, 0, 0, 0, 24'hFF0000);
    check("t4_model_addr", 160'(exp_af[0]), 160'd0);
    check("t4_model_beat1", 160'(exp_wd[0]), 160'({16'h0000, {4{32'h00FF0000}}}));
    drain("t4a");
    push_cmd(0, 0, 3, 3, 24'h0000FF);
    for (int k = 0; k < 4; k++) begin
      check("t4_diag_addr", 160'(exp_af[k]), 160'(k * 512));
      check("t4_diag_m1", 160'(exp_wd[2*k][143:128]), 160'(diag_mask[k]));
    end
    drain("t4b");

    // clipping at H_RES / V_RES
    push_cmd(795, 0, 805, 0, 24'hABCDEF);
    check("clip_h_n", 160'(exp_af.size()), 160'd1);
    check("clip_h_addr", 160'(exp_af[0]), 160'd396);
    check("clip_h_m2", 160'(exp_wd[1][143:128]), 160'h0000);
    drain("clip_h");
    push_cmd(900, 10, 910, 10, 24'h111111);
    check("clip_off_n", 160'(exp_af.size()), 160'd0);
    drain("clip_off");
    push_cmd(0, 599, 0, 600, 24'h222222);
    check("clip_v_n", 160'(exp_af.size()), 160'd1);
    check("clip_v_addr", 160'(exp_af[0]), 160'(599 * 512));
    drain("clip_v");

    // 5: af_full held while WR1 waits
    af_full = 1;
    push_cmd(5, 5, 5, 5, 24'h333333);
    s = af_seen;
    repeat (8) tick();
    check("t5_no_push_held", 160'(af_seen), 160'(s));
    check("t5_busy_held", 160'(busy), 160'd1);
    af_full = 0;
    drain("t5");

    // 6: queue fills while the FSM is stalled; an extra push is dropped
    wdf_full = 1;
    push_cmd(0, 0, 7, 0, 24'h444444);
    tick(); tick();
    for (int k = 0; k < DEPTH; k++) push_cmd(k*10, 1, k*10+3, 1, 24'h555555);
    check("t6_cmd_ready_full", 160'(cmd_ready), 160'd0);
    cmd_valid = 1; cmd_x0 = 100; cmd_y0 = 100; cmd_x1 = 100; cmd_y1 = 100;
    tick();
    cmd_valid = 0;
    check("t6_still_full", 160'(cmd_ready), 160'd0);
    wdf_full = 0;
    drain("t6");

    // reset while WR2 is stalled
    push_cmd(0, 0, 15, 0, 24'h666666);
    push_cmd(20, 2, 30, 2, 24'h777777);
    push_cmd(40, 3, 41, 9, 24'h888888);
    n = 0;
    while (!af_wr_en && n < 50) begin tick(); n++; end
    check("rst_mid_af_seen", 160'(af_wr_en), 160'd1);
    tick();
    wdf_full = 1;
    tick();
    #2 rst_n = 0;
    #1;
    check("rst_mid_af_wr_en", 160'(af_wr_en), 160'd0);
    check("rst_mid_wdf_wr_en", 160'(wdf_wr_en), 160'd0);
    check("rst_mid_busy", 160'(busy), 160'd0);
    check("rst_mid_cmd_ready", 160'(cmd_ready), 160'd1);
    exp_af.delete(); exp_wd.delete();
    wdf_full = 0;
    tick(); tick();
    rst_n = 1;
    repeat (40) tick();
    check("rst_mid_idle_after", 160'(busy), 160'd0);

    // randomized lines, random FIFO back-pressure, new frame base per batch
    for (int bt = 0; bt < 4; bt++) begin
      frame_base = $urandom;
      rand_full = 1;
      for (int k = 0; k < 12; k++) begin
        if (k % 3 == 2) begin
          x0 = int'($urandom_range(770, 830)); y0 = int'($urandom_range(580, 620));
        end else begin
          x0 = int'($urandom_range(0, 1023)); y0 = int'($urandom_range(0, 1023));
        end
        span = (k % 6 == 0) ? 300 : 30;
        x1 = clampc(x0 + int'($urandom_range(0, 2*span)) - span);
        y1 = clampc(y0 + int'($urandom_range(0, 2*span)) - span);
        if (k % 5 == 1) begin x1 = x0; y1 = y0; end
        push_cmd(x0, y0, x1, y1, 24'($urandom));
      end
      drain("rand");
      rand_full = 0; af_full = 0; wdf_full = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end
endmodule
